// File: rtl/ex_mem_if.sv
// EX/MEM stage bus: execute-stage inputs and memory-stage registered outputs.
// bubblecntM exists only when EXMEM_BUBBLE_CNT_EN is defined.
interface ex_mem_if;
  logic        stallE;
  logic        stallM;
  logic        flushM;
  logic [4:0]  writeregjalrE;
  logic [7:0]  alucontrolE;
  logic [31:0] aluoutE;
  logic [31:0] pcplus8E;
  logic [31:0] writedataE;
  logic        linkE;
  logic        regwriteE;
  logic        memtoregE;
  logic        memwriteE;

  logic [4:0]  writeregM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [7:0]  alucontrolM;
  logic        regwriteM;
  logic        memtoregM;
  logic        memwriteM;
  logic        validM;
`ifdef EXMEM_BUBBLE_CNT_EN
  logic [31:0] bubblecntM;
`endif

  modport master (
    output stallE, stallM, flushM, writeregjalrE, alucontrolE, aluoutE,
           pcplus8E, writedataE, linkE, regwriteE, memtoregE, memwriteE,
    input  writeregM, aluoutM, writedataM, alucontrolM, regwriteM,
           memtoregM, memwriteM, validM
`ifdef EXMEM_BUBBLE_CNT_EN
    , input bubblecntM
`endif
  );

  modport slave (
    input  stallE, stallM, flushM, writeregjalrE, alucontrolE, aluoutE,
           pcplus8E, writedataE, linkE, regwriteE, memtoregE, memwriteE,
    output writeregM, aluoutM, writedataM, alucontrolM, regwriteM,
           memtoregM, memwriteM, validM
`ifdef EXMEM_BUBBLE_CNT_EN
    , output bubblecntM
`endif
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall-hold, flush/bubble insertion and $zero write guard.
// Optional bubble counter enabled by EXMEM_BUBBLE_CNT_EN.
module ex_mem_reg (
  input logic     clk,
  input logic     rst,
  ex_mem_if.slave bus
);

  function automatic logic guard_regwrite(input logic rw, input logic [4:0] rd);
    return rw & (rd != 5'd0);
  endfunction

  function automatic logic [31:0] select_result(input logic link,
                                                input logic [31:0] pc8,
                                                input logic [31:0] alu);
    return link ? pc8 : alu;
  endfunction

  logic [31:0] result_p0;
  logic        regwrite_p0;
  logic        load_bubble;
  logic        load_real;

  logic [4:0]  writereg_p1;
  logic [31:0] result_p1;
  logic [31:0] writedata_p1;
  logic [7:0]  alucontrol_p1;
  logic        regwrite_p1;
  logic        memtoreg_p1;
  logic        memwrite_p1;
  logic        vld_p1;

  assign result_p0   = select_result(bus.linkE, bus.pcplus8E, bus.aluoutE);
  assign regwrite_p0 = guard_regwrite(bus.regwriteE, bus.writeregjalrE);

  // A flush beats a hold; a stalled E only inserts a bubble when M is free to advance.
  assign load_bubble = bus.flushM | (~bus.stallM & bus.stallE);
  assign load_real   = ~bus.flushM & ~bus.stallM & ~bus.stallE;

  // ---- E -> M boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      writereg_p1   <= 5'd0;
      result_p1     <= 32'd0;
      writedata_p1  <= 32'd0;
      alucontrol_p1 <= 8'd0;
      regwrite_p1   <= 1'b0;
      memtoreg_p1   <= 1'b0;
      memwrite_p1   <= 1'b0;
      vld_p1        <= 1'b0;
    end else if (load_bubble) begin
      writereg_p1   <= 5'd0;
      result_p1     <= 32'd0;
      writedata_p1  <= 32'd0;
      alucontrol_p1 <= 8'd0;
      regwrite_p1   <= 1'b0;
      memtoreg_p1   <= 1'b0;
      memwrite_p1   <= 1'b0;
      vld_p1        <= 1'b0;
    end else if (load_real) begin
      writereg_p1   <= bus.writeregjalrE;
      result_p1     <= result_p0;
      writedata_p1  <= bus.writedataE;
      alucontrol_p1 <= bus.alucontrolE;
      regwrite_p1   <= regwrite_p0;
      memtoreg_p1   <= bus.memtoregE;
      memwrite_p1   <= bus.memwriteE;
      vld_p1        <= 1'b1;
    end
  end

  assign bus.writeregM   = writereg_p1;
  assign bus.aluoutM     = result_p1;
  assign bus.writedataM  = writedata_p1;
  assign bus.alucontrolM = alucontrol_p1;
  assign bus.regwriteM   = regwrite_p1;
  assign bus.memtoregM   = memtoreg_p1;
  assign bus.memwriteM   = memwrite_p1;
  assign bus.validM      = vld_p1;

`ifdef EXMEM_BUBBLE_CNT_EN
  logic [31:0] bubblecnt_p1;

  // Counts exactly the edges that load a bubble; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubblecnt_p1 <= 32'd0;
    end else if (load_bubble) begin
      bubblecnt_p1 <= bubblecnt_p1 + 32'd1;
    end
  end

  assign bus.bubblecntM = bubblecnt_p1;
`endif

endmodule
